pc_update: RTL
==============

# pc_update

Sequential next-PC unit for the multicycle NPC core: owns the architectural PC register and consumes the `PCAsrc`/`PCBsrc` adder-select pair driven by the branch-condition logic. It forms `dnpc = A + B` and drives the instruction-fetch request/response handshake. It presents the fetched instruction slot to decode/execute and commits `dnpc` into `pc` when execute reports completion. It also keeps a retired-instruction counter.

## Interface
- `RESET_PC`, default `32'h8000_0000`: PC value loaded on reset.
- `clk`  in  1: clock; all state updates on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `PCAsrc`  in  1: adder input A select; 0 = constant 4, 1 = `imm`.
- `PCBsrc`  in  1: adder input B select; 0 = current `pc`, 1 = `rs1`.
- `imm`  in  32: immediate from decode.
- `rs1`  in  32: register-file rs1 read data.
- `ifu_req_valid`  out  1: fetch request valid.
- `ifu_req_ready`  in  1: fetch side accepts the request.
- `ifu_addr`  out  32: fetch address; always equals `pc`.
- `ifu_resp_valid`  in  1: instruction word available; single-cycle pulse.
- `inst_valid`  out  1: instruction slot occupied; execute may evaluate.
- `exu_done`  in  1: execute finished; `PCAsrc`/`PCBsrc`/`imm`/`rs1` are valid this cycle.
- `pc`  out  32: current PC.
- `dnpc`  out  32: combinational next PC.
- `instret`  out  64: retired-instruction count.
- `misalign`  out  1: sticky fetch-misalignment flag; present only with `PC_MISALIGN_TRAP_EN`.

## Operation
- **`dnpc`:** `dnpc = (PCAsrc ? imm : 32'd4) + (PCBsrc ? rs1 : pc)`, modulo 2^32.
  - Bit 0 is forced to 0 when `PCBsrc=1` (JALR rule).
  - Encoding `PCAsrc=0, PCBsrc=1` (`rs1+4`) is not produced upstream; compute it by the same formula anyway.
- **FSM states:** `S_IDLE`, `S_REQ`, `S_WAIT`, `S_EXEC` (plus `S_HALT` with the macro).
  - `S_IDLE`: all handshake outputs 0; next state `S_REQ` unconditionally.
  - `S_REQ`: `ifu_req_valid=1`; go to `S_WAIT` when `ifu_req_ready=1`, else stay.
  - `S_WAIT`: wait for `ifu_resp_valid`, then go to `S_EXEC`.
  - `S_EXEC`: `inst_valid=1`. On `exu_done=1`: `pc <= dnpc`, `instret <= instret + 1`, next state `S_REQ`.
- **Ignored inputs:**
  - `ifu_resp_valid` outside `S_WAIT` (including the accepting `S_REQ` cycle).
  - `exu_done` outside `S_EXEC`.
- `pc` changes only on a commit or on reset.
- `instret` wraps from `2^64-1` to 0 without any flag.

## Timing
- **Reset values (cycle after `rst` sampled high):**
  - `pc=RESET_PC`, `instret=0`, state `S_IDLE`.
  - `ifu_req_valid=0`, `inst_valid=0`, `misalign=0`.
- **Reset mid-operation:** `rst` asserted in any state aborts the in-flight fetch/execute with no commit. A response arriving later is ignored, because the FSM is back in `S_IDLE`/`S_REQ` rather than `S_WAIT`.
- **First request:** `ifu_req_valid` rises 2 cycles after the last `rst`-high edge (`S_IDLE` then `S_REQ`).
- **Minimum throughput:** 3 cycles per instruction (`S_REQ`, `S_WAIT`, `S_EXEC`), when ready, response and done each arrive in their first eligible cycle.
- **`ifu_addr` stability:** stable from the first `S_REQ` cycle through the commit edge.
- **`dnpc` validity:** combinational from current inputs; meaningful only in a cycle where `exu_done=1` in `S_EXEC`.
- **Commit edge:** new `pc` is visible the cycle after `exu_done`; `ifu_req_valid` is 1 in that same cycle.

## Configuration
- **`PC_MISALIGN_TRAP_EN` defined:**
  - In `S_EXEC` with `exu_done=1` and `dnpc[1:0]!=0`: no commit; `pc` and `instret` hold.
  - FSM enters `S_HALT` and `misalign` becomes 1.
  - `S_HALT` drives `ifu_req_valid=0` and `inst_valid=0` and leaves only on `rst`.
- **`PC_MISALIGN_TRAP_EN` undefined:**
  - `misalign` port and `S_HALT` are absent.
  - A misaligned `dnpc` commits unchanged, apart from the JALR bit-0 clear.

## Test plan
- **Reset and first fetch:** hold `rst` 3 cycles, release → `pc=32'h8000_0000`, `instret=0`; `ifu_req_valid` rises on cycle 2 with `ifu_addr=32'h8000_0000`.
- **Sequential commit:** `ready`/`resp`/`done` each immediate with `PCAsrc=0`, `PCBsrc=0` → `pc` steps `8000_0000`, `8000_0004`, `8000_0008` every 3 cycles; `instret` counts 1, 2.
- **Branch taken and JALR:**
  - `PCAsrc=1`, `PCBsrc=0`, `imm=32'hFFFF_FFF8` at `pc=8000_0010` → `pc=8000_0008`.
  - `PCAsrc=1`, `PCBsrc=1`, `rs1=8000_0101`, `imm=2` → `pc=8000_0102` (bit 0 cleared).
- **Handshake stalls:** hold `ifu_req_ready=0` 4 cycles, then pulse `ifu_resp_valid` during `S_REQ` (ignored), then 5 idle cycles in `S_WAIT` → no state advance, `ifu_addr` constant. A spurious `exu_done` in `S_WAIT` → no commit.
- **Reset mid-operation:** assert `rst` in `S_EXEC` coincident with `exu_done=1` → `pc=RESET_PC`, `instret` unchanged-to-0, no commit; a late `ifu_resp_valid` two cycles later is ignored.
- **Misalignment:** `PCAsrc=1`, `PCBsrc=0`, `imm=2` at `pc=8000_0000`.
  - With `PC_MISALIGN_TRAP_EN`: `misalign=1`, `pc=8000_0000`, `ifu_req_valid` stays 0 until `rst`.
  - Without it: `pc=8000_0002`.

Source files
------------

// File: rtl/pc_update.sv
// pc_update: architectural PC register, next-PC adder and the fetch/execute handshake FSM.
// Define PC_MISALIGN_TRAP_EN to halt on a misaligned next PC instead of committing it.
module pc_update #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCAsrc,
  input  logic        PCBsrc,
  input  logic [31:0] imm,
  input  logic [31:0] rs1,
  output logic        ifu_req_valid,
  input  logic        ifu_req_ready,
  output logic [31:0] ifu_addr,
  input  logic        ifu_resp_valid,
  output logic        inst_valid,
  input  logic        exu_done,
  output logic [31:0] pc,
  output logic [31:0] dnpc,
  output logic [63:0] instret
`ifdef PC_MISALIGN_TRAP_EN
  ,
  output logic        misalign
`endif
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_EXEC = 3'd3;
`ifdef PC_MISALIGN_TRAP_EN
  localparam logic [2:0] S_HALT = 3'd4;
`endif

  logic [2:0]  state_q;
  logic [2:0]  state_d;
  logic [31:0] pc_q;
  logic [63:0] instret_q;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic [31:0] sum;
  logic        exec_done;
  logic        commit;
`ifdef PC_MISALIGN_TRAP_EN
  logic        trap;
  logic        misalign_q;
`endif

  assign add_a = PCAsrc ? imm : 32'd4;
  assign add_b = PCBsrc ? rs1 : pc_q;
  assign sum   = add_a + add_b;
  // JALR targets always have bit 0 cleared
  assign dnpc  = PCBsrc ? {sum[31:1], 1'b0} : sum;

  assign exec_done = (state_q == S_EXEC) && exu_done;
`ifdef PC_MISALIGN_TRAP_EN
  assign trap     = exec_done && (dnpc[1:0] != 2'b00);
  assign commit   = exec_done && !trap;
  assign misalign = misalign_q;
`else
  assign commit   = exec_done;
`endif

  assign ifu_req_valid = (state_q == S_REQ);
  assign inst_valid    = (state_q == S_EXEC);
  assign ifu_addr      = pc_q;
  assign pc            = pc_q;
  assign instret       = instret_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ:  if (ifu_req_ready) state_d = S_WAIT;
      S_WAIT: if (ifu_resp_valid) state_d = S_EXEC;
      S_EXEC: begin
        if (exu_done) begin
`ifdef PC_MISALIGN_TRAP_EN
          state_d = trap ? S_HALT : S_REQ;
`else
          state_d = S_REQ;
`endif
        end
      end
`ifdef PC_MISALIGN_TRAP_EN
      S_HALT: state_d = S_HALT;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      instret_q <= 64'd0;
`ifdef PC_MISALIGN_TRAP_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (commit) begin
        pc_q      <= dnpc;
        instret_q <= instret_q + 64'd1;
      end
`ifdef PC_MISALIGN_TRAP_EN
      if (trap) misalign_q <= 1'b1;
`endif
    end
  end

endmodule
